// File: rtl/notas_pkg.sv
// rtl/notas_pkg.sv - shared widths, state/phase types and sizing helpers for sequenciador_notas
package notas_pkg;

    localparam int NOTE_W = 7;
    localparam int ADDR_W = 4;
    localparam int SEL_W  = 3;
    localparam logic [ADDR_W-1:0] LAST_STEP = 4'd15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_SHOW,
        ST_GAP,
        ST_WAIT_PLAY,
        ST_CHECK,
        ST_WIN,
        ST_LOSE
    } estado_t;

    // mostra: the melody is being played back; joga: the player is answering
    typedef enum logic {
        FASE_MOSTRA,
        FASE_JOGA
    } fase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The shared counter only ever holds (cycles - 1), so clog2(max) bits suffice
    function automatic int cnt_width(input int max_cycles);
        return (max_cycles < 2) ? 1 : $clog2(max_cycles);
    endfunction

endpackage

// File: rtl/contador_tempo.sv
// rtl/contador_tempo.sv - loadable down counter timing the SHOW, GAP and WAIT_PLAY windows
module contador_tempo #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         enable,
    output logic         done
);

    logic [W-1:0] count;

    // Load has priority; the count parks at zero so a stalled window never wraps
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (enable && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    // A window loaded with N-1 lasts N enabled cycles; done marks the last one
    assign done = enable && (count == '0);

endmodule

// File: rtl/sequenciador_notas.sv
// rtl/sequenciador_notas.sv - Simon-style melody sequencer: plays note memory on LEDs and checks presses
module sequenciador_notas
    import notas_pkg::*;
#(
    parameter int NOTE_CYCLES    = 25_000_000,
    parameter int GAP_CYCLES     = 12_500_000,
    parameter int TIMEOUT_CYCLES = 250_000_000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic [SEL_W-1:0]  select_musica,
    output logic [ADDR_W-1:0] address,
    output logic [SEL_W-1:0]  select_out,
    input  logic [NOTE_W-1:0] nota_mem,
    input  logic              jogada,
    input  logic [NOTE_W-1:0] botoes,
    output logic [NOTE_W-1:0] leds,
    output logic [ADDR_W-1:0] rodada,
    output logic              pronto,
    output logic              acertou,
    output logic              errou
);

    localparam int CNT_MAX = max3(NOTE_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);
    localparam int CNT_W   = cnt_width(CNT_MAX);

    localparam logic [CNT_W-1:0] NOTE_LOAD    = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD     = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    estado_t             estado;
    fase_t               fase;
    logic [ADDR_W-1:0]   idx;
    logic [NOTE_W-1:0]   nota_reg;
    logic [NOTE_W-1:0]   botoes_reg;

    logic                cnt_load;
    logic [CNT_W-1:0]    cnt_value;
    logic                cnt_en;
    logic                cnt_done;
    logic                erro_jogada;

    // The counter only runs in the three timed states
    assign cnt_en = (estado == ST_SHOW) || (estado == ST_GAP) || (estado == ST_WAIT_PLAY);

    // A wrong note includes anything that is not exactly one button
    assign erro_jogada = (botoes_reg != nota_reg) || !$onehot(botoes_reg);

    // Arm the counter on the cycle before each timed state is entered
    always_comb begin
        cnt_load  = 1'b0;
        cnt_value = '0;
        case (estado)
            ST_LOAD: begin
                cnt_load  = 1'b1;
                cnt_value = (fase == FASE_MOSTRA) ? NOTE_LOAD : TIMEOUT_LOAD;
            end
            ST_SHOW: begin
                if (cnt_done) begin
                    cnt_load  = 1'b1;
                    cnt_value = GAP_LOAD;
                end
            end
            default: ;
        endcase
    end

    contador_tempo #(
        .W (CNT_W)
    ) u_contador (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (cnt_load),
        .value   (cnt_value),
        .enable  (cnt_en),
        .done    (cnt_done)
    );

    // Game FSM; address is updated on the edge entering FETCH so the memory has LOAD to respond
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado     <= ST_IDLE;
            fase       <= FASE_MOSTRA;
            idx        <= '0;
            nota_reg   <= '0;
            botoes_reg <= '0;
            address    <= '0;
            select_out <= '0;
            leds       <= '0;
            rodada     <= '0;
            pronto     <= 1'b1;
            acertou    <= 1'b0;
            errou      <= 1'b0;
        end else begin
            case (estado)
                ST_IDLE, ST_WIN, ST_LOSE: begin
                    if (iniciar) begin
                        select_out <= select_musica;
                        rodada     <= '0;
                        idx        <= '0;
                        address    <= '0;
                        fase       <= FASE_MOSTRA;
                        acertou    <= 1'b0;
                        errou      <= 1'b0;
                        pronto     <= 1'b0;
                        estado     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    address <= idx;
                    estado  <= ST_LOAD;
                end
                ST_LOAD: begin
                    nota_reg <= nota_mem;
                    if (fase == FASE_MOSTRA) begin
                        leds   <= nota_mem;
                        estado <= ST_SHOW;
                    end else begin
                        estado <= ST_WAIT_PLAY;
                    end
                end
                ST_SHOW: begin
                    if (cnt_done) begin
                        leds   <= '0;
                        estado <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_done) begin
                        if (idx < rodada) begin
                            idx     <= idx + 4'd1;
                            address <= idx + 4'd1;
                        end else begin
                            idx     <= '0;
                            address <= '0;
                            fase    <= FASE_JOGA;
                        end
                        estado <= ST_FETCH;
                    end
                end
                ST_WAIT_PLAY: begin
                    // A press in the expiry cycle still counts
                    if (jogada) begin
                        botoes_reg <= botoes;
                        estado     <= ST_CHECK;
                    end else if (cnt_done) begin
                        errou  <= 1'b1;
                        estado <= ST_LOSE;
                    end
                end
                ST_CHECK: begin
                    if (erro_jogada) begin
                        errou  <= 1'b1;
                        estado <= ST_LOSE;
                    end else if (idx < rodada) begin
                        idx     <= idx + 4'd1;
                        address <= idx + 4'd1;
                        estado  <= ST_FETCH;
                    end else if (rodada == LAST_STEP) begin
                        acertou <= 1'b1;
                        estado  <= ST_WIN;
                    end else begin
                        rodada  <= rodada + 4'd1;
                        idx     <= '0;
                        address <= '0;
                        fase    <= FASE_MOSTRA;
                        estado  <= ST_FETCH;
                    end
                end
                default: begin
                    estado <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
